// File: rtl/clint_pkg.sv
// Shared address map, register-select decode type and small helpers for the
// multi-hart CLINT.
package clint_pkg;

  localparam logic [31:0] MSIP_BASE     = 32'h0000_0000;
  localparam logic [31:0] MTIMECMP_BASE = 32'h0000_4000;
  localparam logic [31:0] MTIMECMP_END  = 32'h0000_8000;
  localparam logic [31:0] MTIME_LO      = 32'h0000_BFF8;
  localparam logic [31:0] MTIME_HI      = 32'h0000_BFFC;

  typedef enum logic [2:0] {
    REG_NONE,
    REG_MSIP,
    REG_CMP_LO,
    REG_CMP_HI,
    REG_MTIME_LO,
    REG_MTIME_HI
  } reg_sel_e;

  // msip slots are one word apart, mtimecmp slots two words apart
  function automatic int unsigned hart_index(input logic [31:0] addr);
    if (addr < MTIMECMP_BASE) return (addr - MSIP_BASE) >> 2;
    return (addr - MTIMECMP_BASE) >> 3;
  endfunction

  function automatic logic [31:0] byte_merge(input logic [31:0] old_val,
                                             input logic [31:0] new_val,
                                             input logic [3:0]  sel);
    logic [31:0] r;
    r = old_val;
    for (int unsigned b = 0; b < 4; b++) begin
      if (sel[b]) r[8*b +: 8] = new_val[8*b +: 8];
    end
    return r;
  endfunction

endpackage

// File: rtl/clint_mh_if.sv
// Wishbone B4 classic bus bundle for the CLINT slave port.
interface clint_mh_if #(parameter int unsigned ADDR_W = 16) ();
  logic              wb_cyc_i;
  logic              wb_stb_i;
  logic              wb_we_i;
  logic [ADDR_W-1:0] wb_adr_i;
  logic [3:0]        wb_sel_i;
  logic [31:0]       wb_dat_i;
  logic [31:0]       wb_dat_o;
  logic              wb_ack_o;

  modport slave (
    input  wb_cyc_i, wb_stb_i, wb_we_i, wb_adr_i, wb_sel_i, wb_dat_i,
    output wb_dat_o, wb_ack_o
  );

  modport master (
    output wb_cyc_i, wb_stb_i, wb_we_i, wb_adr_i, wb_sel_i, wb_dat_i,
    input  wb_dat_o, wb_ack_o
  );
endinterface

// File: rtl/clint_tick_gen.sv
// mtime prescaler: pulses tick once every TICK_DIV clocks (always high when
// TICK_DIV is 1).
module clint_tick_gen #(
  parameter int unsigned TICK_DIV = 1
) (
  input  logic clk,
  input  logic rst_n,
  output logic tick
);

  localparam int unsigned CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    tick  = (cnt_q == CW'(TICK_DIV - 1));
    cnt_d = tick ? '0 : cnt_q + CW'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/clint_mh.sv
// Multi-hart CLINT: shared prescaled 64-bit mtime, per-hart msip and mtimecmp,
// Wishbone classic slave with a registered single-cycle ack.
module clint_mh
  import clint_pkg::*;
#(
  parameter int unsigned NUM_HARTS = 2,
  parameter int unsigned TICK_DIV  = 1,
  parameter int unsigned ADDR_W    = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  clint_mh_if.slave            bus,
  output logic [NUM_HARTS-1:0] software_int,
  output logic [NUM_HARTS-1:0] timer_int
);

  localparam int unsigned HW = (NUM_HARTS > 1) ? $clog2(NUM_HARTS) : 1;

  logic                       tick;
  logic                       req, wr_en;
  logic [31:0]                adr;
  int unsigned                hart;
  logic [HW-1:0]              hidx;
  reg_sel_e                   rsel;
  logic [31:0]                rd;
  logic [63:0]                mtime_q, mtime_d;
  logic                       ack_q, ack_d;
  logic [31:0]                dat_q, dat_d;
  logic [NUM_HARTS-1:0]       msip_all;
  logic [NUM_HARTS-1:0][63:0] cmp_all;

  clint_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
    .clk   (clk),
    .rst_n (rst_n),
    .tick  (tick)
  );

  assign req   = bus.wb_cyc_i & bus.wb_stb_i & ~ack_q;
  assign wr_en = req & bus.wb_we_i;

  always_comb begin
    adr  = 32'(bus.wb_adr_i[ADDR_W-1:0]) & ~32'h3;
    hart = hart_index(adr);
    hidx = HW'(hart);
    rsel = REG_NONE;
    if (adr < MTIMECMP_BASE) begin
      if (hart < NUM_HARTS) rsel = REG_MSIP;
    end else if (adr < MTIMECMP_END) begin
      if (hart < NUM_HARTS) rsel = adr[2] ? REG_CMP_HI : REG_CMP_LO;
    end else if (adr == MTIME_LO) begin
      rsel = REG_MTIME_LO;
    end else if (adr == MTIME_HI) begin
      rsel = REG_MTIME_HI;
    end
  end

  // Bus-written bytes override the incremented value; unwritten bytes keep it,
  // so a carry out of the low word still reaches an unwritten high word.
  always_comb begin
    mtime_d = mtime_q + 64'(tick);
    if (wr_en && rsel == REG_MTIME_LO)
      mtime_d[31:0]  = byte_merge(mtime_d[31:0], bus.wb_dat_i, bus.wb_sel_i);
    if (wr_en && rsel == REG_MTIME_HI)
      mtime_d[63:32] = byte_merge(mtime_d[63:32], bus.wb_dat_i, bus.wb_sel_i);
  end

  for (genvar h = 0; h < NUM_HARTS; h++) begin : g_hart
    logic        msip_q, msip_d;
    logic        ti_q, ti_d;
    logic [63:0] cmp_q, cmp_d;

    always_comb begin
      msip_d = msip_q;
      cmp_d  = cmp_q;
      if (wr_en && hidx == HW'(h)) begin
        case (rsel)
          REG_MSIP:   if (bus.wb_sel_i[0]) msip_d = bus.wb_dat_i[0];
          REG_CMP_LO: cmp_d[31:0]  = byte_merge(cmp_q[31:0],  bus.wb_dat_i, bus.wb_sel_i);
          REG_CMP_HI: cmp_d[63:32] = byte_merge(cmp_q[63:32], bus.wb_dat_i, bus.wb_sel_i);
          default:    ;
        endcase
      end
      ti_d = (mtime_q >= cmp_q);
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        msip_q <= 1'b0;
        cmp_q  <= '1;
        ti_q   <= 1'b0;
      end else begin
        msip_q <= msip_d;
        cmp_q  <= cmp_d;
        ti_q   <= ti_d;
      end
    end

    assign software_int[h] = msip_q;
    assign timer_int[h]    = ti_q;
    assign msip_all[h]     = msip_q;
    assign cmp_all[h]      = cmp_q;
  end

  always_comb begin
    rd = '0;
    case (rsel)
      REG_MSIP:     rd = {31'b0, msip_all[hidx]};
      REG_CMP_LO:   rd = cmp_all[hidx][31:0];
      REG_CMP_HI:   rd = cmp_all[hidx][63:32];
      REG_MTIME_LO: rd = mtime_q[31:0];
      REG_MTIME_HI: rd = mtime_q[63:32];
      default:      rd = '0;
    endcase
    ack_d = req;
    dat_d = req ? rd : '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mtime_q <= '0;
      ack_q   <= 1'b0;
      dat_q   <= '0;
    end else begin
      mtime_q <= mtime_d;
      ack_q   <= ack_d;
      dat_q   <= dat_d;
    end
  end

  assign bus.wb_ack_o = ack_q;
  assign bus.wb_dat_o = dat_q;

endmodule
